// File: rtl/subinst_sched_pkg.sv
// Shared types and default sizes for the sub-instance round-robin scheduler.
package subinst_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } sched_state_e;

  localparam int NUM_REQ_DEFAULT  = 5;
  localparam int MAX_HOLD_DEFAULT = 16;

endpackage

// File: rtl/subinst_rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or after ptr, wrapping.
module subinst_rr_pick
  import subinst_sched_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               any_req,
  output logic [ID_W-1:0]    winner
);

  always_comb begin
    int idx;
    idx     = 0;
    any_req = 1'b0;
    winner  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = int'(ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!any_req && req[idx]) begin
        any_req = 1'b1;
        winner  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/subinst_rr_scheduler.sv
// Round-robin scheduler sharing one resource among NUM_REQ child instances.
// Optional hold-limit preemption with timeout_o pulse: define SUBINST_RR_SCHED_TIMEOUT_EN.
module subinst_rr_scheduler
  import subinst_sched_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEFAULT,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               busy
`ifdef SUBINST_RR_SCHED_TIMEOUT_EN
  ,
  output logic               timeout_o
`endif
);

  if (NUM_REQ < 2) begin : g_chk_req
    $error("subinst_rr_scheduler: NUM_REQ must be at least 2");
  end
  if (MAX_HOLD < 2) begin : g_chk_hold
    $error("subinst_rr_scheduler: MAX_HOLD must be at least 2");
  end

  sched_state_e    state;
  logic [ID_W-1:0] ptr;
  logic            any_req;
  logic [ID_W-1:0] winner;
  logic            holder_done;
  logic            holder_gone;
  logic            release_c;
  logic [ID_W-1:0] next_ptr;

  subinst_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .any_req (any_req),
    .winner  (winner)
  );

  assign holder_done = done[gnt_id];
  assign holder_gone = !req[gnt_id];
  assign next_ptr    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

`ifdef SUBINST_RR_SCHED_TIMEOUT_EN
  localparam int HC_W = $clog2(MAX_HOLD);
  logic [HC_W-1:0] hold_cnt;
  logic            hold_expired;

  assign hold_expired = (hold_cnt == HC_W'(MAX_HOLD - 1));
  assign release_c    = holder_done || holder_gone || hold_expired;
`else
  assign release_c    = holder_done || holder_gone;
`endif

  assign gnt_valid = |gnt;
  assign busy      = (state != IDLE);

  // RELEASE arbitrates like IDLE so back-to-back grants are separated by one dead cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      gnt_id <= '0;
      ptr    <= '0;
`ifdef SUBINST_RR_SCHED_TIMEOUT_EN
      hold_cnt  <= '0;
      timeout_o <= 1'b0;
`endif
    end else begin
`ifdef SUBINST_RR_SCHED_TIMEOUT_EN
      timeout_o <= 1'b0;
`endif
      unique case (state)
        IDLE, RELEASE: begin
          if (any_req) begin
            state  <= GRANT;
            gnt    <= NUM_REQ'(1) << winner;
            gnt_id <= winner;
`ifdef SUBINST_RR_SCHED_TIMEOUT_EN
            hold_cnt <= '0;
`endif
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (release_c) begin
            state <= RELEASE;
            gnt   <= '0;
            ptr   <= next_ptr;
`ifdef SUBINST_RR_SCHED_TIMEOUT_EN
            timeout_o <= !holder_done && !holder_gone;
`endif
          end
`ifdef SUBINST_RR_SCHED_TIMEOUT_EN
          if (!hold_expired) hold_cnt <= hold_cnt + 1'b1;
`endif
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subinst_rr_scheduler.sv
// Self-checking bench for subinst_rr_scheduler (NUM_REQ = 5), table vectors plus corner sequences.
module tb_subinst_rr_scheduler;

  localparam int NUM_REQ = 5;
  localparam int ID_W    = 3;
`ifdef SUBINST_RR_SCHED_TIMEOUT_EN
  localparam int MAX_HOLD = 4;
`else
  localparam int MAX_HOLD = 16;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_REQ-1:0] req = '0;
  logic [NUM_REQ-1:0] done = '0;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_valid;
  logic [ID_W-1:0]    gnt_id;
  logic               busy;
`ifdef SUBINST_RR_SCHED_TIMEOUT_EN
  logic               timeout_o;
`endif

  typedef struct {
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    id;
    logic               busy;
    logic               tmo;
    string              name;
  } exp_t;

  typedef struct {
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] done;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]    id;
    logic               busy;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[14];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  subinst_rr_scheduler #(
    .NUM_REQ  (NUM_REQ),
    .ID_W     (ID_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .busy      (busy)
`ifdef SUBINST_RR_SCHED_TIMEOUT_EN
    ,
    .timeout_o (timeout_o)
`endif
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, want);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 expected=1");
      return;
    end
    e = sb.pop_front();
    cmp({e.name, ".gnt"},       32'(gnt),       32'(e.gnt));
    cmp({e.name, ".gnt_id"},    32'(gnt_id),    32'(e.id));
    cmp({e.name, ".busy"},      32'(busy),      32'(e.busy));
    cmp({e.name, ".gnt_valid"}, 32'(gnt_valid), 32'(|e.gnt));
    cmp({e.name, ".onehot0"},   32'($onehot0(gnt)), 32'd1);
`ifdef SUBINST_RR_SCHED_TIMEOUT_EN
    cmp({e.name, ".timeout_o"}, 32'(timeout_o), 32'(e.tmo));
`endif
  endtask

  // Drive inputs for one cycle, record what must appear after the next edge, then check it
  task automatic apply(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ-1:0] d,
                       input logic [NUM_REQ-1:0] eg, input logic [ID_W-1:0] eid,
                       input logic eb, input logic etmo, input string nm);
    exp_t e;
    req  = r;
    done = d;
    e.gnt = eg; e.id = eid; e.busy = eb; e.tmo = etmo; e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out();
  endtask

  initial begin
    int holder;

    vecs[0]  = '{5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b1};
    vecs[1]  = '{5'b00100, 5'b00000, 5'b00100, 3'd2, 1'b1};
    vecs[2]  = '{5'b00100, 5'b00100, 5'b00000, 3'd2, 1'b1};
    vecs[3]  = '{5'b00000, 5'b00000, 5'b00000, 3'd2, 1'b0};
    vecs[4]  = '{5'b00000, 5'b11111, 5'b00000, 3'd2, 1'b0};
    vecs[5]  = '{5'b01000, 5'b00000, 5'b01000, 3'd3, 1'b1};
    vecs[6]  = '{5'b01000, 5'b01000, 5'b00000, 3'd3, 1'b1};
    vecs[7]  = '{5'b00011, 5'b00000, 5'b00001, 3'd0, 1'b1};
    vecs[8]  = '{5'b00011, 5'b00010, 5'b00001, 3'd0, 1'b1};
    vecs[9]  = '{5'b00011, 5'b00001, 5'b00000, 3'd0, 1'b1};
    vecs[10] = '{5'b10001, 5'b00000, 5'b10000, 3'd4, 1'b1};
    vecs[11] = '{5'b10000, 5'b00000, 5'b10000, 3'd4, 1'b1};
    vecs[12] = '{5'b00001, 5'b00000, 5'b00000, 3'd4, 1'b1};
    vecs[13] = '{5'b00000, 5'b00000, 5'b00000, 3'd4, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    cmp("reset.gnt",       32'(gnt),       32'd0);
    cmp("reset.gnt_id",    32'(gnt_id),    32'd0);
    cmp("reset.busy",      32'(busy),      32'd0);
    cmp("reset.gnt_valid", 32'(gnt_valid), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++)
      apply(vecs[i].req, vecs[i].done, vecs[i].gnt, vecs[i].id, vecs[i].busy, 1'b0,
            $sformatf("vec%0d", i));

    // All requesting: holders rotate 0,1,2,3,4,0, three grant cycles then one dead cycle
    for (int k = 0; k < 6; k++) begin
      holder = k % NUM_REQ;
      apply(5'b11111, 5'b00000, 5'(1 << holder), 3'(holder), 1'b1, 1'b0, $sformatf("rr%0d_c1", k));
      apply(5'b11111, 5'b00000, 5'(1 << holder), 3'(holder), 1'b1, 1'b0, $sformatf("rr%0d_c2", k));
      apply(5'b11111, 5'b00000, 5'(1 << holder), 3'(holder), 1'b1, 1'b0, $sformatf("rr%0d_c3", k));
      apply(5'b11111, 5'(1 << holder), 5'b00000, 3'(holder), 1'b1, 1'b0, $sformatf("rr%0d_rel", k));
    end
    apply(5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, "rr_idle");

    // Reset asserted mid-grant clears outputs without waiting for a clock edge
    apply(5'b01000, 5'b00000, 5'b01000, 3'd3, 1'b1, 1'b0, "rst_pre");
    #2 rst = 1'b1;
    #1;
    cmp("rst_mid.gnt",       32'(gnt),       32'd0);
    cmp("rst_mid.busy",      32'(busy),      32'd0);
    cmp("rst_mid.gnt_id",    32'(gnt_id),    32'd0);
    cmp("rst_mid.gnt_valid", 32'(gnt_valid), 32'd0);
    #2 rst = 1'b0;
    apply(5'b01010, 5'b00000, 5'b00010, 3'd1, 1'b1, 1'b0, "rst_ptr0");
    apply(5'b01010, 5'b00010, 5'b00000, 3'd1, 1'b1, 1'b0, "rst_rel");
    apply(5'b00000, 5'b00000, 5'b00000, 3'd1, 1'b0, 1'b0, "rst_idle");

`ifdef SUBINST_RR_SCHED_TIMEOUT_EN
    for (int c = 0; c < MAX_HOLD; c++)
      apply(5'b00011, 5'b00000, 5'b00001, 3'd0, 1'b1, 1'b0, $sformatf("to_hold%0d", c));
    apply(5'b00011, 5'b00000, 5'b00000, 3'd0, 1'b1, 1'b1, "to_release");
    apply(5'b00011, 5'b00000, 5'b00010, 3'd1, 1'b1, 1'b0, "to_next");
    apply(5'b00011, 5'b00010, 5'b00000, 3'd1, 1'b1, 1'b0, "to_next_rel");
    apply(5'b00000, 5'b00000, 5'b00000, 3'd1, 1'b0, 1'b0, "to_idle");
`else
    for (int c = 0; c < 20; c++)
      apply(5'b00011, 5'b00000, 5'b00001, 3'd0, 1'b1, 1'b0, $sformatf("nto_hold%0d", c));
    apply(5'b00010, 5'b00000, 5'b00000, 3'd0, 1'b1, 1'b0, "nto_abandon");
    apply(5'b00000, 5'b00000, 5'b00000, 3'd0, 1'b0, 1'b0, "nto_idle");
`endif

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover actual=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
